// File: rtl/pc_unit.sv
// Program-counter generator for the fetch front end: stepped PC, stall hold, redirect buffering.
// Define PC_UNIT_TRAP_EN to add the trap input, trap vector and misaligned-target trapping.
module pc_unit #(
  parameter int unsigned       ADDR_W     = 32,
  parameter int unsigned       STEP       = 4,
  parameter logic [ADDR_W-1:0] RESET_ADDR = '0
`ifdef PC_UNIT_TRAP_EN
  ,
  parameter logic [ADDR_W-1:0] TRAP_ADDR  = ADDR_W'(32'h0000_0100)
`endif
) (
  input  logic              clk_i_PCU,
  input  logic              reset_i_PCU,
  input  logic              stall_i_PCU,
  input  logic              redirect_valid_i_PCU,
  input  logic [ADDR_W-1:0] redirect_addr_i_PCU,
`ifdef PC_UNIT_TRAP_EN
  input  logic              trap_valid_i_PCU,
  output logic              misalign_o_PCU,
`endif
  output logic [ADDR_W-1:0] pc_addr_o_PCU,
  output logic              chip_enable_o_PCU,
  output logic              pending_o_PCU
);

  typedef enum logic [1:0] {StOff, StRun, StHold} state_e;

  localparam logic [ADDR_W-1:0] StepW     = ADDR_W'(STEP);
  localparam logic [ADDR_W-1:0] AlignMask = ~(StepW - 1'b1);

  state_e            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_pc, w_pc_nxt;
  logic              r_ce, w_ce_nxt;
  logic              r_pending, w_pending_nxt;
  logic [ADDR_W-1:0] r_pend_addr, w_pend_addr_nxt;
  logic [ADDR_W-1:0] w_tgt, w_next_pc;
`ifdef PC_UNIT_TRAP_EN
  logic              r_pend_trap, w_pend_trap_nxt;
  logic              r_misalign, w_misalign_nxt;
  logic              w_tgt_chk, w_mis;
`endif

  // Target selection; later assignments take priority over earlier ones.
  always_comb begin
    w_tgt = r_pc + StepW;
`ifdef PC_UNIT_TRAP_EN
    w_tgt_chk = 1'b0;
    if (r_pending) begin
      w_tgt     = r_pend_addr;
      w_tgt_chk = 1'b1;
    end
    if (redirect_valid_i_PCU) begin
      w_tgt     = redirect_addr_i_PCU;
      w_tgt_chk = 1'b1;
    end
    if (trap_valid_i_PCU) begin
      w_tgt     = TRAP_ADDR;
      w_tgt_chk = 1'b0;
    end
    w_mis     = w_tgt_chk && (|(w_tgt & ~AlignMask));
    w_next_pc = w_mis ? TRAP_ADDR : w_tgt;
`else
    if (r_pending) w_tgt = r_pend_addr;
    if (redirect_valid_i_PCU) w_tgt = redirect_addr_i_PCU;
    w_next_pc = w_tgt & AlignMask;
`endif
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_pc_nxt        = r_pc;
    w_ce_nxt        = r_ce;
    w_pending_nxt   = r_pending;
    w_pend_addr_nxt = r_pend_addr;
`ifdef PC_UNIT_TRAP_EN
    w_pend_trap_nxt = r_pend_trap;
    w_misalign_nxt  = 1'b0;
`endif
    case (r_state)
      StOff: begin
        w_state_nxt = StRun;
        w_ce_nxt    = 1'b1;
      end
      StRun, StHold: begin
        if (stall_i_PCU) begin
          w_state_nxt = StHold;
`ifdef PC_UNIT_TRAP_EN
          // A buffered trap is sticky against later redirects in the same stall.
          if (trap_valid_i_PCU) begin
            w_pending_nxt   = 1'b1;
            w_pend_addr_nxt = TRAP_ADDR;
            w_pend_trap_nxt = 1'b1;
          end else if (redirect_valid_i_PCU && !r_pend_trap) begin
            w_pending_nxt   = 1'b1;
            w_pend_addr_nxt = redirect_addr_i_PCU;
          end
`else
          if (redirect_valid_i_PCU) begin
            w_pending_nxt   = 1'b1;
            w_pend_addr_nxt = redirect_addr_i_PCU;
          end
`endif
        end else begin
          w_state_nxt   = StRun;
          w_pc_nxt      = w_next_pc;
          w_pending_nxt = 1'b0;
`ifdef PC_UNIT_TRAP_EN
          w_pend_trap_nxt = 1'b0;
          w_misalign_nxt  = w_mis;
`endif
        end
      end
      default: w_state_nxt = StOff;
    endcase
  end

  always_ff @(posedge clk_i_PCU or negedge reset_i_PCU) begin
    if (!reset_i_PCU) begin
      r_state     <= StOff;
      r_pc        <= RESET_ADDR;
      r_ce        <= 1'b0;
      r_pending   <= 1'b0;
      r_pend_addr <= '0;
`ifdef PC_UNIT_TRAP_EN
      r_pend_trap <= 1'b0;
      r_misalign  <= 1'b0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_pc        <= w_pc_nxt;
      r_ce        <= w_ce_nxt;
      r_pending   <= w_pending_nxt;
      r_pend_addr <= w_pend_addr_nxt;
`ifdef PC_UNIT_TRAP_EN
      r_pend_trap <= w_pend_trap_nxt;
      r_misalign  <= w_misalign_nxt;
`endif
    end
  end

  assign pc_addr_o_PCU     = r_pc;
  assign chip_enable_o_PCU = r_ce;
  assign pending_o_PCU     = r_pending;
`ifdef PC_UNIT_TRAP_EN
  assign misalign_o_PCU    = r_misalign;
`endif

endmodule

// File: doc/pc_unit.md
# pc_unit

Parametrised program-counter generator for the core's fetch front end; successor to the fixed-width, increment-by-one PC. It drives the instruction address and chip enable to Instru_Fetch, advances by a configurable step, and holds on a stall. It accepts a redirect from branch/jump resolution and buffers a redirect that arrives while stalled. It optionally vectors to a trap address.

## Interface
Parameters:
- `ADDR_W`, default 32: PC width in bits.
- `STEP`, default 4: sequential increment; power of two, 1..2^(ADDR_W-1).
- `RESET_ADDR`, default 0: PC value while and after reset; must be STEP-aligned.
- `TRAP_ADDR`, default 32'h0000_0100: trap vector. Used only with `PC_UNIT_TRAP_EN`; must be STEP-aligned.

Ports:
- `clk_i_PCU`, in, 1: the single clock; all state changes on its rising edge.
- `reset_i_PCU`, in, 1: asynchronous, active-low reset.
- `stall_i_PCU`, in, 1: hold the current PC.
- `redirect_valid_i_PCU`, in, 1: a redirect request is present this cycle.
- `redirect_addr_i_PCU`, in, ADDR_W: redirect target.
- `trap_valid_i_PCU`, in, 1: trap request. Present only with `PC_UNIT_TRAP_EN`.
- `pc_addr_o_PCU`, out, ADDR_W: registered instruction address.
- `chip_enable_o_PCU`, out, 1: registered fetch enable.
- `pending_o_PCU`, out, 1: a buffered redirect is waiting.
- `misalign_o_PCU`, out, 1: one-cycle pulse when a misaligned target is taken. Present only with `PC_UNIT_TRAP_EN`.

## Operation
- States: OFF, RUN, HOLD. A 2-bit register holds the state.
- Reset asserted, asynchronously:
  - state = OFF, pc = RESET_ADDR, chip enable = 0.
  - pending = 0, pending address = 0, misalign = 0.
- OFF: the first edge with reset deasserted moves to RUN and sets chip enable = 1. The PC stays RESET_ADDR, so RESET_ADDR is the first fetched address.
- RUN, stall = 0: pc <= next_pc.
- RUN, stall = 1: go to HOLD; the PC holds. Chip enable stays 1.
- HOLD, stall = 1: the PC holds.
- HOLD, stall = 0: pc <= next_pc; go to RUN.
- next_pc priority, highest first:
  1. trap, with the macro only: TRAP_ADDR.
  2. Live redirect this cycle: redirect_addr.
  3. Pending redirect: pending address; pending is cleared.
  4. Otherwise pc + STEP, truncated to ADDR_W bits. 2^ADDR_W − STEP wraps to 0.
- Redirect while stall = 1:
  - The address is latched and pending = 1.
  - A later redirect during the same stall overwrites it; last wins.
  - The PC does not move.
- A live redirect on the stall-release cycle beats the pending one; pending is cleared.
- Trap while stall = 1, with the macro: latched into the pending slot as TRAP_ADDR. A later redirect in the same stall does not overwrite a pending trap.
- Redirect or trap in state OFF: ignored.
- Alignment, for STEP > 1: the low log2(STEP) bits of the target are checked.
  - Without the macro, those bits are forced to 0.
  - With the macro, a misaligned target is replaced by TRAP_ADDR and misalign pulses for one cycle, coincident with the PC update.
- Reset asserted mid-stall or with a redirect pending: everything returns to reset values immediately; the pending redirect is lost.

## Timing
- Redirect to PC latency: 1 edge. Present redirect in cycle n, unstalled; pc_addr_o equals the target after edge n.
- Buffered redirect: appears on pc_addr_o after the first unstalled edge.
- pending_o rises on the edge after the stalled redirect, and falls on the edge that applies it.
- Chip enable: 0 during reset; 1 from the first edge after reset release; never drops except on reset.
- All outputs are registers; there are no combinational input-to-output paths.

## Configuration
- `PC_UNIT_TRAP_EN` defined:
  - `trap_valid_i_PCU`, `misalign_o_PCU` and TRAP_ADDR exist.
  - Trap priority and misaligned-target trapping are active.
- `PC_UNIT_TRAP_EN` undefined:
  - Those ports and that logic are absent.
  - Misaligned targets are silently aligned down.

## Test plan
- Reset and run, defaults (STEP=4, RESET_ADDR=0): release reset, 4 edges. Required pc sequence: 0, 0, 4, 8, 0xC; chip enable 0 then 1 from the first edge.
- Stall: pc = 0x10, stall for 3 edges. pc stays 0x10 for all three; after release the next edge gives 0x14.
- Stalled redirect: while stalled, present 0x200 then 0x300 on two cycles. pending = 1; release stall; pc = 0x300; pending = 0.
- Live beats pending: with 0x300 pending, present redirect 0x400 on the release cycle. Required pc = 0x400, pending = 0.
- Wrap, ADDR_W=8, STEP=4: from pc = 0xFC, one edge gives pc = 0x00.
- Misalign:
  - With the macro: redirect 0x102 gives pc = TRAP_ADDR and a one-cycle misalign pulse.
  - Without the macro: the same redirect gives pc = 0x100.
